layer_buffer_mgr: RTL and testbench
===================================

LAYER_BUFFER_MGR -- requirements
Module: layer_buffer_mgr

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 8: number of layer partitions.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16: unified memory depth is 2^ADDR_WIDTH words.
REQ-003 SHALL have parameter DATA_WIDTH, default 32: word width.
REQ-004 SHALL have derived parameter LID_W = max(1, $clog2(NUM_LAYERS)): layer-id width.
REQ-005 SHALL have one clock and an asynchronous, active-high reset.
REQ-006 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-007 SHALL have port rst, input, 1: asynchronous reset, active-high.
REQ-008 SHALL have cfg_wr_en, input, 1: write one layer-table entry.
REQ-009 SHALL have cfg_layer_id, input, LID_W: entry to write.
REQ-010 SHALL have cfg_base, input, ADDR_WIDTH: partition base word address.
REQ-011 SHALL have cfg_size, input, ADDR_WIDTH+1: partition size in words; 0 disables the layer.
REQ-012 SHALL have host_wr_valid, input, 1; host_wr_ready, output, 1; host_layer_id, input, LID_W; host_addr, input, ADDR_WIDTH (offset); host_wdata, input, DATA_WIDTH.
REQ-013 SHALL have rd_req, input, 1; rd_layer, input, LID_W; rd_addr, input, ADDR_WIDTH (offset).
REQ-014 SHALL have rd_valid, output, 1; rd_data, output, DATA_WIDTH; rd_err, output, 1.
REQ-015 SHALL have layer_ready, output, NUM_LAYERS: per-layer load-complete flags.
REQ-016 SHALL have oob_err, output, 1: sticky bounds-violation flag; err_count, output, 8: saturating violation count.

Function
REQ-017 SHALL hold a table of NUM_LAYERS entries {base, size}, written on the rising edge when cfg_wr_en=1.
REQ-018 SHALL compute the physical address as (base + offset) mod 2^ADDR_WIDTH; wrap-around is legal and not an error.
REQ-019 SHALL treat an access as out-of-bounds when offset >= size, or when the layer id >= NUM_LAYERS.
REQ-020 SHALL drive host_wr_ready = !cfg_wr_en, so configuration writes take priority over host data writes.
REQ-021 SHALL write host_wdata to memory when host_wr_valid && host_wr_ready and the access is in bounds; an out-of-bounds write SHALL be dropped, still counts as accepted, and is counted as an error.
REQ-022 SHALL set layer_ready[i] on an accepted in-bounds write to layer i at offset size-1.
REQ-023 SHALL clear layer_ready[i] on any cfg write to entry i; if a set and a clear occur in the same cycle, the clear SHALL win.
REQ-024 SHALL give reads a fixed latency of 1 cycle: a request in cycle N produces rd_valid=1 in cycle N+1 only, with one read accepted per cycle and no backpressure.
REQ-025 SHALL, for an out-of-bounds read, return rd_data=0 and rd_err=1 with rd_valid=1; otherwise rd_err=0.
REQ-026 SHALL resolve the table entry for a read or write from its values before any same-cycle cfg write to that entry.
REQ-027 SHALL be read-first when a read and a write hit the same physical address in the same cycle: the read returns the old data.
REQ-028 SHALL, on each read or write violation, set oob_err and increment err_count, saturating at 255; a simultaneous read and write violation SHALL add 2, saturating.
REQ-029 SHALL hold rd_data at its last value while rd_valid=0.

Reset
REQ-030 SHALL, while rst=1, clear every table entry to base=0, size=0, and force rd_valid=0, rd_data=0, rd_err=0, layer_ready=0, oob_err=0, err_count=0.
REQ-031 SHALL NOT clear memory contents on reset.
REQ-032 SHALL discard a read in flight when reset is asserted: no rd_valid pulse after reset release.
REQ-033 SHALL drive host_wr_ready from the combinational rule only, so it is 1 during reset when cfg_wr_en=0; writes issued during reset SHALL be ignored.
REQ-034 SHALL, after reset, treat every access as out-of-bounds until its layer is configured.

Verification
REQ-035 SHALL verify: cfg layer 2 {base=0x0100, size=4}; write offsets 0..3 with data 0xA0..0xA3 -> layer_ready[2]=1 after the offset-3 write; read offset 2 -> next cycle rd_valid=1, rd_data=0xA2.
REQ-036 SHALL verify: read layer 2 offset 4 -> rd_valid=1, rd_err=1, rd_data=0, oob_err=1, err_count=1.
REQ-037 SHALL verify: cfg layer 7 {base=0xFFFE, size=4}; write offset 3 with data 0x55 -> physical address 0x0001 holds 0x55, no error.
REQ-038 SHALL verify: same-cycle write 0x77 and read at the same physical address that held 0x11 -> rd_data=0x11; a following read returns 0x77.
REQ-039 SHALL verify: cfg_wr_en=1 concurrent with host_wr_valid=1 -> host_wr_ready=0, no memory write, layer_ready of the reconfigured layer cleared.
REQ-040 SHALL verify: 300 out-of-bounds reads -> err_count=255; then rst pulse -> err_count=0, all table sizes 0, and memory data still present after reconfiguring the layer.

Source files
------------

// File: rtl/layer_buffer_mgr.sv
// layer_buffer_mgr: partitions one unified word memory into per-layer windows.
// A small table maps {layer id, offset} to a physical address with bounds
// checking. Host writes fill a layer, and layer_ready marks a layer whose
// last word has been written. Reads have a fixed one-cycle latency.
// Handshake: a host write is accepted in any cycle where host_wr_valid and
// host_wr_ready are both 1. host_wr_ready is simply !cfg_wr_en. Reads have
// no backpressure.
module layer_buffer_mgr #(
    parameter int NUM_LAYERS = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int LID_W      = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_wr_en,
    input  logic [LID_W-1:0]      cfg_layer_id,
    input  logic [ADDR_WIDTH-1:0] cfg_base,
    input  logic [ADDR_WIDTH:0]   cfg_size,
    input  logic                  host_wr_valid,
    output logic                  host_wr_ready,
    input  logic [LID_W-1:0]      host_layer_id,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    input  logic                  rd_req,
    input  logic [LID_W-1:0]      rd_layer,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_err,
    output logic [NUM_LAYERS-1:0] layer_ready,
    output logic                  oob_err,
    output logic [7:0]            err_count
);

    logic [ADDR_WIDTH-1:0] r_base [NUM_LAYERS];
    logic [ADDR_WIDTH:0]   r_size [NUM_LAYERS];
    logic [DATA_WIDTH-1:0] r_mem  [2**ADDR_WIDTH];
    logic [NUM_LAYERS-1:0] r_layer_ready;
    logic                  r_rd_valid;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_err;
    logic                  r_oob_err;
    logic [7:0]            r_err_count;

    logic [ADDR_WIDTH-1:0] w_wr_base;
    logic [ADDR_WIDTH:0]   w_wr_size;
    logic                  w_wr_lid_ok;
    logic [ADDR_WIDTH-1:0] w_rd_base;
    logic [ADDR_WIDTH:0]   w_rd_size;
    logic                  w_rd_lid_ok;
    logic [NUM_LAYERS-1:0] w_cfg_hit;
    logic [NUM_LAYERS-1:0] w_wr_hit;
    logic                  w_wr_inb;
    logic                  w_wr_last;
    logic                  w_rd_inb;
    logic [ADDR_WIDTH-1:0] w_wr_phys;
    logic [ADDR_WIDTH-1:0] w_rd_phys;
    logic                  w_host_acc;
    logic                  w_mem_we;
    logic                  w_wr_viol;
    logic                  w_rd_viol;
    logic [8:0]            w_err_sum;

    assign host_wr_ready = !cfg_wr_en;
    assign w_host_acc    = host_wr_valid && host_wr_ready;

    // Table lookup for both ports from registered entries (pre-cfg-write values);
    // ids beyond NUM_LAYERS match no entry and are flagged as out of bounds.
    always_comb begin
        w_wr_base   = '0;
        w_wr_size   = '0;
        w_wr_lid_ok = 1'b0;
        w_rd_base   = '0;
        w_rd_size   = '0;
        w_rd_lid_ok = 1'b0;
        w_cfg_hit   = '0;
        w_wr_hit    = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (host_layer_id == LID_W'(i)) begin
                w_wr_base   = r_base[i];
                w_wr_size   = r_size[i];
                w_wr_lid_ok = 1'b1;
                w_wr_hit[i] = 1'b1;
            end
            if (rd_layer == LID_W'(i)) begin
                w_rd_base   = r_base[i];
                w_rd_size   = r_size[i];
                w_rd_lid_ok = 1'b1;
            end
            if (cfg_wr_en && (cfg_layer_id == LID_W'(i))) begin
                w_cfg_hit[i] = 1'b1;
            end
        end
    end

    // Physical address wraps modulo the memory depth; only offset vs size is checked.
    assign w_wr_phys = w_wr_base + host_addr;
    assign w_rd_phys = w_rd_base + rd_addr;
    assign w_wr_inb  = w_wr_lid_ok && ({1'b0, host_addr} < w_wr_size);
    assign w_rd_inb  = w_rd_lid_ok && ({1'b0, rd_addr} < w_rd_size);
    assign w_wr_last = ({1'b0, host_addr} == (w_wr_size - {{ADDR_WIDTH{1'b0}}, 1'b1}));
    assign w_mem_we  = w_host_acc && w_wr_inb && !rst;
    assign w_wr_viol = w_host_acc && !w_wr_inb;
    assign w_rd_viol = rd_req && !w_rd_inb;
    assign w_err_sum = {1'b0, r_err_count} + {8'd0, w_wr_viol} + {8'd0, w_rd_viol};

    // Layer table: cleared by reset, written by cfg port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                r_base[i] <= '0;
                r_size[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                if (w_cfg_hit[i]) begin
                    r_base[i] <= cfg_base;
                    r_size[i] <= cfg_size;
                end
            end
        end
    end

    // Unified memory, never reset; writes are gated off while rst is high.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_wr_phys] <= host_wdata;
        end
    end

    // Load-complete flags: reconfiguring an entry clears it, which beats a set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_layer_ready <= '0;
        end else begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                if (w_cfg_hit[i]) begin
                    r_layer_ready[i] <= 1'b0;
                end else if (w_host_acc && w_wr_inb && w_wr_last && w_wr_hit[i]) begin
                    r_layer_ready[i] <= 1'b1;
                end
            end
        end
    end

    // Read port: one-cycle latency, read-first against a same-cycle write,
    // data held between responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_rd_err   <= 1'b0;
        end else begin
            r_rd_valid <= rd_req;
            r_rd_err   <= w_rd_viol;
            if (rd_req) begin
                r_rd_data <= w_rd_inb ? r_mem[w_rd_phys] : '0;
            end
        end
    end

    // Sticky violation flag and saturating count (a read and write violation add 2).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_oob_err   <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_oob_err   <= r_oob_err | w_wr_viol | w_rd_viol;
            r_err_count <= w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
        end
    end

    assign rd_valid    = r_rd_valid;
    assign rd_data     = r_rd_data;
    assign rd_err      = r_rd_err;
    assign layer_ready = r_layer_ready;
    assign oob_err     = r_oob_err;
    assign err_count   = r_err_count;

endmodule

// File: tb/tb_layer_buffer_mgr.sv
// Testbench for layer_buffer_mgr: directed scenarios plus a randomized run,
// all checked against a behavioural model (table arrays, associative memory).
module tb_layer_buffer_mgr;

    logic        clk;
    logic        rst;
    logic        cfg_wr_en;
    logic [2:0]  cfg_layer_id;
    logic [15:0] cfg_base;
    logic [16:0] cfg_size;
    logic        host_wr_valid;
    logic        host_wr_ready;
    logic [2:0]  host_layer_id;
    logic [15:0] host_addr;
    logic [31:0] host_wdata;
    logic        rd_req;
    logic [2:0]  rd_layer;
    logic [15:0] rd_addr;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        rd_err;
    logic [7:0]  layer_ready;
    logic        oob_err;
    logic [7:0]  err_count;

    int n_vec;
    int n_err;

    // reference model state
    int          m_base [8];
    int          m_size [8];
    logic [31:0] m_mem [int];
    logic [7:0]  m_ready;
    logic        m_oob;
    int          m_cnt;
    logic        exp_rv;
    logic        exp_re;
    logic [31:0] exp_rd;
    bit          exp_known;

    layer_buffer_mgr dut (
        .clk(clk), .rst(rst),
        .cfg_wr_en(cfg_wr_en), .cfg_layer_id(cfg_layer_id),
        .cfg_base(cfg_base), .cfg_size(cfg_size),
        .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
        .host_layer_id(host_layer_id), .host_addr(host_addr), .host_wdata(host_wdata),
        .rd_req(rd_req), .rd_layer(rd_layer), .rd_addr(rd_addr),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err),
        .layer_ready(layer_ready), .oob_err(oob_err), .err_count(err_count)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit is_oob(int lid, int off);
        return (lid >= 8) || (off >= m_size[lid]);
    endfunction

    task automatic idle();
        cfg_wr_en = 0; cfg_layer_id = 0; cfg_base = 0; cfg_size = 0;
        host_wr_valid = 0; host_layer_id = 0; host_addr = 0; host_wdata = 0;
        rd_req = 0; rd_layer = 0; rd_addr = 0;
    endtask

    // Apply the current inputs to the model, then advance the DUT one clock
    // and land on the falling edge where outputs are sampled.
    task automatic cycle();
        int n;
        int p;
        n = 0;
        if (rst) begin
            for (int i = 0; i < 8; i++) begin m_base[i] = 0; m_size[i] = 0; end
            m_ready = 0; m_oob = 0; m_cnt = 0;
            exp_rv = 0; exp_re = 0; exp_rd = 0; exp_known = 1;
        end else begin
            if (rd_req) begin
                exp_rv = 1;
                if (is_oob(int'(rd_layer), int'(rd_addr))) begin
                    exp_rd = 0; exp_re = 1; exp_known = 1; n++;
                end else begin
                    exp_re = 0;
                    p = (m_base[rd_layer] + int'(rd_addr)) % 65536;
                    if (m_mem.exists(p)) begin exp_rd = m_mem[p]; exp_known = 1; end
                    else exp_known = 0;
                end
            end else begin
                exp_rv = 0; exp_re = 0;
            end
            if (host_wr_valid && !cfg_wr_en) begin
                if (is_oob(int'(host_layer_id), int'(host_addr))) n++;
                else begin
                    p = (m_base[host_layer_id] + int'(host_addr)) % 65536;
                    m_mem[p] = host_wdata;
                    if (int'(host_addr) == m_size[host_layer_id] - 1) m_ready[host_layer_id] = 1;
                end
            end
            m_cnt = (m_cnt + n > 255) ? 255 : m_cnt + n;
            if (n > 0) m_oob = 1;
            if (cfg_wr_en) begin
                m_ready[cfg_layer_id] = 0;
                m_base[cfg_layer_id]  = int'(cfg_base);
                m_size[cfg_layer_id]  = int'(cfg_size);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_cfg(input int lid, input int base, input int size);
        idle();
        cfg_wr_en = 1; cfg_layer_id = 3'(lid); cfg_base = 16'(base); cfg_size = 17'(size);
        cycle();
    endtask

    task automatic do_wr(input int lid, input int off, input logic [31:0] d);
        idle();
        host_wr_valid = 1; host_layer_id = 3'(lid); host_addr = 16'(off); host_wdata = d;
        cycle();
    endtask

    task automatic do_rd(input int lid, input int off);
        idle();
        rd_req = 1; rd_layer = 3'(lid); rd_addr = 16'(off);
        cycle();
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        cycle();
        cycle();
        n_vec++; if (rd_valid !== 1'b0 || rd_err !== 1'b0 || rd_data !== 32'h0) begin
            n_err++; $display("FAIL reset_rd: got v=%b e=%b d=%h want 0 0 0", rd_valid, rd_err, rd_data); end
        n_vec++; if (layer_ready !== 8'h00 || oob_err !== 1'b0 || err_count !== 8'h00) begin
            n_err++; $display("FAIL reset_status: got rdy=%h oob=%b cnt=%0d want 0 0 0", layer_ready, oob_err, err_count); end
        n_vec++; if (host_wr_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_wr_ready: got %b want 1", host_wr_ready); end
        rst = 0;
        #1;
    endtask

    task automatic test_basic();
        do_cfg(2, 16'h0100, 4);
        for (int i = 0; i < 4; i++) begin
            do_wr(2, i, 32'hA0 + i);
            n_vec++; if (layer_ready[2] !== (i == 3)) begin
                n_err++; $display("FAIL basic_ready_off%0d: got %b want %b", i, layer_ready[2], (i == 3)); end
        end
        do_rd(2, 2);
        n_vec++; if (rd_valid !== 1'b1 || rd_err !== 1'b0 || rd_data !== 32'hA2) begin
            n_err++; $display("FAIL basic_rd: got v=%b e=%b d=%h want 1 0 000000a2", rd_valid, rd_err, rd_data); end
        idle();
        cycle();
        n_vec++; if (rd_valid !== 1'b0 || rd_data !== 32'hA2) begin
            n_err++; $display("FAIL basic_hold: got v=%b d=%h want 0 000000a2", rd_valid, rd_data); end
    endtask

    task automatic test_oob();
        do_rd(2, 4);
        n_vec++; if (rd_valid !== 1'b1 || rd_err !== 1'b1 || rd_data !== 32'h0) begin
            n_err++; $display("FAIL oob_rd: got v=%b e=%b d=%h want 1 1 0", rd_valid, rd_err, rd_data); end
        n_vec++; if (oob_err !== 1'b1 || err_count !== 8'd1) begin
            n_err++; $display("FAIL oob_count: got oob=%b cnt=%0d want 1 1", oob_err, err_count); end
        idle();
        host_wr_valid = 1; host_layer_id = 2; host_addr = 9; host_wdata = 32'hBAD;
        rd_req = 1; rd_layer = 3; rd_addr = 0;
        cycle();
        n_vec++; if (err_count !== 8'd3 || layer_ready[2] !== 1'b1) begin
            n_err++; $display("FAIL oob_double: got cnt=%0d rdy2=%b want 3 1", err_count, layer_ready[2]); end
    endtask

    task automatic test_wrap();
        do_cfg(7, 16'hFFFE, 4);
        do_cfg(0, 0, 16);
        do_wr(7, 3, 32'h55);
        n_vec++; if (err_count !== 8'd3) begin
            n_err++; $display("FAIL wrap_no_err: got cnt=%0d want 3", err_count); end
        do_rd(0, 1);
        n_vec++; if (rd_err !== 1'b0 || rd_data !== 32'h55) begin
            n_err++; $display("FAIL wrap_phys1: got e=%b d=%h want 0 00000055", rd_err, rd_data); end
        do_rd(7, 3);
        n_vec++; if (rd_data !== 32'h55) begin
            n_err++; $display("FAIL wrap_l7: got %h want 00000055", rd_data); end
    endtask

    task automatic test_read_first();
        do_wr(0, 5, 32'h11);
        idle();
        host_wr_valid = 1; host_layer_id = 0; host_addr = 5; host_wdata = 32'h77;
        rd_req = 1; rd_layer = 0; rd_addr = 5;
        cycle();
        n_vec++; if (rd_data !== 32'h11) begin
            n_err++; $display("FAIL rf_old: got %h want 00000011", rd_data); end
        do_rd(0, 5);
        n_vec++; if (rd_data !== 32'h77) begin
            n_err++; $display("FAIL rf_new: got %h want 00000077", rd_data); end
    endtask

    task automatic test_cfg_priority();
        idle();
        cfg_wr_en = 1; cfg_layer_id = 2; cfg_base = 16'h0100; cfg_size = 4;
        host_wr_valid = 1; host_layer_id = 2; host_addr = 0; host_wdata = 32'hDEAD;
        #1;
        n_vec++; if (host_wr_ready !== 1'b0) begin
            n_err++; $display("FAIL prio_ready: got %b want 0", host_wr_ready); end
        cycle();
        n_vec++; if (layer_ready[2] !== 1'b0 || err_count !== 8'd3) begin
            n_err++; $display("FAIL prio_clear: got rdy2=%b cnt=%0d want 0 3", layer_ready[2], err_count); end
        do_rd(2, 0);
        n_vec++; if (rd_data !== 32'hA0) begin
            n_err++; $display("FAIL prio_nowrite: got %h want 000000a0", rd_data); end
    endtask

    task automatic test_saturate_reset();
        for (int i = 0; i < 300; i++) begin
            do_rd(3, 0);
            if (i == 9) begin
                n_vec++; if (err_count !== 8'd13) begin
                    n_err++; $display("FAIL sat_mid: got %0d want 13", err_count); end
            end
        end
        n_vec++; if (err_count !== 8'd255 || oob_err !== 1'b1) begin
            n_err++; $display("FAIL sat_end: got cnt=%0d oob=%b want 255 1", err_count, oob_err); end
        // reset with a read and a write presented: both must vanish
        idle();
        rd_req = 1; rd_layer = 0; rd_addr = 5;
        host_wr_valid = 1; host_layer_id = 0; host_addr = 5; host_wdata = 32'h99;
        rst = 1;
        #1;
        n_vec++; if (err_count !== 8'd0 || oob_err !== 1'b0 || layer_ready !== 8'h00) begin
            n_err++; $display("FAIL rst_status: got cnt=%0d oob=%b rdy=%h want 0 0 0", err_count, oob_err, layer_ready); end
        cycle();
        idle();
        rst = 0;
        cycle();
        n_vec++; if (rd_valid !== 1'b0 || rd_data !== 32'h0) begin
            n_err++; $display("FAIL rst_inflight: got v=%b d=%h want 0 0", rd_valid, rd_data); end
        for (int l = 0; l < 8; l++) begin
            do_rd(l, 0);
            n_vec++; if (rd_err !== 1'b1 || rd_valid !== 1'b1) begin
                n_err++; $display("FAIL rst_size0_l%0d: got e=%b v=%b want 1 1", l, rd_err, rd_valid); end
        end
        n_vec++; if (err_count !== 8'd8) begin
            n_err++; $display("FAIL rst_count: got %0d want 8", err_count); end
        do_cfg(0, 0, 16);
        do_rd(0, 5);
        n_vec++; if (rd_err !== 1'b0 || rd_data !== 32'h77) begin
            n_err++; $display("FAIL rst_mem_keep0: got e=%b d=%h want 0 00000077", rd_err, rd_data); end
        do_cfg(2, 16'h0100, 4);
        do_rd(2, 2);
        n_vec++; if (rd_data !== 32'hA2) begin
            n_err++; $display("FAIL rst_mem_keep2: got %h want 000000a2", rd_data); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            idle();
            if ($urandom_range(0, 15) == 0) begin
                cfg_wr_en = 1; cfg_layer_id = 3'($urandom_range(0, 3));
                cfg_base = 16'($urandom_range(0, 31)); cfg_size = 17'($urandom_range(0, 8));
            end
            if ($urandom_range(0, 1) == 1) begin
                host_wr_valid = 1; host_layer_id = 3'($urandom_range(0, 3));
                host_addr = 16'($urandom_range(0, 9)); host_wdata = $urandom;
            end
            if ($urandom_range(0, 1) == 1) begin
                rd_req = 1; rd_layer = 3'($urandom_range(0, 7)); rd_addr = 16'($urandom_range(0, 9));
            end
            #1;
            n_vec++; if (host_wr_ready !== !cfg_wr_en) begin
                n_err++; $display("FAIL rnd_ready c%0d: got %b want %b", c, host_wr_ready, !cfg_wr_en); end
            cycle();
            n_vec++; if (rd_valid !== exp_rv || rd_err !== exp_re) begin
                n_err++; $display("FAIL rnd_rd_flags c%0d: got v=%b e=%b want %b %b", c, rd_valid, rd_err, exp_rv, exp_re); end
            if (exp_known) begin
                n_vec++; if (rd_data !== exp_rd) begin
                    n_err++; $display("FAIL rnd_rd_data c%0d: got %h want %h", c, rd_data, exp_rd); end
            end
            n_vec++; if (layer_ready !== m_ready || oob_err !== m_oob || err_count !== 8'(m_cnt)) begin
                n_err++; $display("FAIL rnd_status c%0d: got rdy=%h oob=%b cnt=%0d want %h %b %0d",
                                  c, layer_ready, oob_err, err_count, m_ready, m_oob, m_cnt); end
        end
    endtask

    // test sequence and final report
    initial begin
        n_vec = 0;
        n_err = 0;
        exp_known = 1;
        idle();
        rst = 1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_oob();
        test_wrap();
        test_read_first();
        test_cfg_priority();
        test_saturate_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
